// File: rtl/gb_mbc1.sv
// gb_mbc1: MBC1 cartridge mapper bridging the cart bus to a req/ack backing store.
// Define GB_MBC1_RAM_EN to enable cart RAM at A000-BFFF (otherwise it reads 8'hFF).
module gb_mbc1 #(
  parameter int ROM_ADDR_BITS = 21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cart_addr,
  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  output logic [7:0]  cart_do,
  output logic        cart_busy,
  output logic [21:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);
  localparam logic [21:0] ROM_MASK = 22'((64'd1 << ROM_ADDR_BITS) - 64'd1);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t      state;
  logic        rd_d, wr_d, mode;
  logic [4:0]  rom_lo;
  logic [1:0]  bank_hi;
  logic [15:0] last_addr;
  logic        wr_rise, rd_rise, is_rom, is_ram, rd_go, bank_wr;
  logic [6:0]  rom_bank;
  logic [21:0] rom_addr;
  assign wr_rise   = cart_wr & ~wr_d;
  assign rd_rise   = cart_rd & ~rd_d;
  assign is_rom    = ~cart_addr[15];
  assign is_ram    = cart_addr[15:13] == 3'b101;
  assign bank_wr   = wr_rise & is_rom;
  assign rd_go     = state == IDLE && cart_rd && (is_rom || is_ram) && (rd_rise || cart_addr != last_addr);
  assign rom_bank  = cart_addr[14] ? {bank_hi, rom_lo} : (mode ? {bank_hi, 5'b0} : 7'd0);
  assign rom_addr  = {1'b0, rom_bank, cart_addr[13:0]} & ROM_MASK;
  assign cart_busy = state != IDLE;
`ifdef GB_MBC1_RAM_EN
  logic        ram_en, pend_v, ram_wr;
  logic [21:0] ram_addr, pend_addr;
  logic [7:0]  pend_data;
  assign ram_addr = {1'b1, 6'b0, mode ? bank_hi : 2'b00, cart_addr[12:0]};
  assign ram_wr   = wr_rise & is_ram & ram_en;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ram_en <= 1'b0;
    else if (bank_wr && cart_addr[14:13] == 2'd0) ram_en <= cart_di[3:0] == 4'hA;
  // one-deep slot; a newer edge simply overwrites whatever is waiting
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (ram_wr && (state != IDLE || pend_v)) begin
      pend_v    <= 1'b1;
      pend_addr <= ram_addr;
      pend_data <= cart_di;
    end else if (state == IDLE) pend_v <= 1'b0;
`else
  logic unused_di;
  assign unused_di = ^cart_di[7:5];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_d    <= 1'b0;
      wr_d    <= 1'b0;
      rom_lo  <= 5'd1;
      bank_hi <= 2'd0;
      mode    <= 1'b0;
    end else begin
      rd_d <= cart_rd;
      wr_d <= cart_wr;
      if (bank_wr && cart_addr[14:13] == 2'd1) rom_lo <= cart_di[4:0] == 5'd0 ? 5'd1 : cart_di[4:0];
      if (bank_wr && cart_addr[14:13] == 2'd2) bank_hi <= cart_di[1:0];
      if (bank_wr && cart_addr[14:13] == 2'd3) mode <= cart_di[0];
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cart_do   <= 8'hFF;
      last_addr <= 16'hFFFF;
    end else if (state != IDLE) begin
      if (mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == RD) cart_do <= mem_rdata;
      end
    end
`ifdef GB_MBC1_RAM_EN
    else if (pend_v) begin
      state     <= WR;
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= pend_addr;
      mem_wdata <= pend_data;
    end else if (ram_wr) begin
      state     <= WR;
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= ram_addr;
      mem_wdata <= cart_di;
    end
`endif
    else if (rd_go) begin
      last_addr <= cart_addr;
      if (is_rom) begin
        state    <= RD;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= rom_addr;
      end
`ifdef GB_MBC1_RAM_EN
      else if (ram_en) begin
        state    <= RD;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= ram_addr;
      end
`endif
      else cart_do <= 8'hFF;
    end
endmodule

// File: tb/tb_gb_mbc1.sv
// tb_gb_mbc1: directed plus randomized checks of gb_mbc1 against an arithmetic mapper model.
module tb_gb_mbc1;
`ifdef GB_MBC1_RAM_EN
  localparam bit RAM_BUILD = 1'b1;
`else
  localparam bit RAM_BUILD = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [15:0] cart_addr = '0;
  logic        cart_rd = 1'b0, cart_wr = 1'b0;
  logic [7:0]  cart_di = '0, cart_do, mem_wdata, mem_rdata = '0;
  logic        cart_busy, mem_req, mem_we, mem_ack = 1'b0;
  logic [21:0] mem_addr, obs_addr;
  int n_chk = 0, n_fail = 0;
  int m_ram_en = 0, m_rom_lo = 1, m_bank_hi = 0, m_mode = 0;

  gb_mbc1 dut (
    .clk(clk), .reset_n(reset_n), .cart_addr(cart_addr), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .cart_do(cart_do), .cart_busy(cart_busy), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] rom_exp(input int a);
    int bank;
    bank = a < 'h4000 ? (m_mode != 0 ? m_bank_hi * 32 : 0) : m_bank_hi * 32 + m_rom_lo;
    return 22'((bank * 16384 + a % 16384) % (1 << 21));
  endfunction

  function automatic logic [21:0] ram_exp(input int a);
    return 22'((1 << 21) + (m_mode != 0 ? m_bank_hi : 0) * 8192 + a % 8192);
  endfunction

  function automatic logic [7:0] dat(input int e);
    return 8'((e ^ (e >> 8) ^ (e >> 16)) & 127);
  endfunction

  function automatic void model_reset();
    m_ram_en = 0; m_rom_lo = 1; m_bank_hi = 0; m_mode = 0;
  endfunction

  task automatic cwr(input logic [15:0] a, input logic [7:0] d);
    bit exp_req;
    logic [21:0] ea;
    exp_req = RAM_BUILD && a >= 16'hA000 && a < 16'hC000 && m_ram_en != 0;
    ea = ram_exp(int'(a));
    cart_addr = a; cart_di = d; cart_wr = 1'b1;
    cyc(1);
    cart_wr = 1'b0;
    chk("wr_req", {31'b0, mem_req}, {31'b0, exp_req});
    if (exp_req) begin
      chk("wr_we", {31'b0, mem_we}, 32'd1);
      chk("wr_addr", {10'b0, mem_addr}, {10'b0, ea});
      chk("wr_data", {24'b0, mem_wdata}, {24'b0, d});
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      chk("wr_done", {31'b0, cart_busy}, 32'd0);
    end else cyc(1);
    if (a < 16'h2000) m_ram_en = (d % 16) == 10 ? 1 : 0;
    else if (a < 16'h4000) m_rom_lo = (d % 32) == 0 ? 1 : d % 32;
    else if (a < 16'h6000) m_bank_hi = d % 4;
    else if (a < 16'h8000) m_mode = d % 2;
  endtask

  task automatic crd(input logic [15:0] a, input int dly);
    bit exp_req;
    logic [21:0] ea;
    exp_req = a < 16'h8000 || (RAM_BUILD && m_ram_en != 0);
    ea = a < 16'h8000 ? rom_exp(int'(a)) : ram_exp(int'(a));
    cart_addr = a; cart_rd = 1'b1;
    cyc(1);
    chk("rd_req", {31'b0, mem_req}, {31'b0, exp_req});
    obs_addr = mem_addr;
    if (exp_req) begin
      chk("rd_addr", {10'b0, mem_addr}, {10'b0, ea});
      chk("rd_we", {31'b0, mem_we}, 32'd0);
      chk("rd_busy", {31'b0, cart_busy}, 32'd1);
      cyc(dly);
      chk("rd_hold", {10'b0, mem_addr}, {10'b0, ea});
      mem_ack = 1'b1; mem_rdata = dat(int'(ea));
      cyc(1);
      mem_ack = 1'b0;
      chk("rd_data", {24'b0, cart_do}, {24'b0, dat(int'(ea))});
      chk("rd_drop", {31'b0, mem_req}, 32'd0);
    end else chk("rd_ff", {24'b0, cart_do}, 32'hFF);
    cart_rd = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    chk("rst_do", {24'b0, cart_do}, 32'hFF);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, cart_busy}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    reset_n = 1'b1;
    cyc(1);
    cwr(16'h2000, 8'h00);
    crd(16'h4123, 2);
    chk("rom_bank0_as_1", {10'b0, obs_addr}, 32'h004123);
    cwr(16'h4000, 8'h03);
    cwr(16'h6000, 8'h01);
    crd(16'h0010, 0);
    chk("mode1_low_bank", {10'b0, obs_addr}, 32'h180010);
    cwr(16'h6000, 8'h00);
    crd(16'h0010, 1);
    chk("mode0_low_bank", {10'b0, obs_addr}, 32'h000010);
    cwr(16'h2000, 8'h1F);
    crd(16'h7FFF, 3);
    crd(16'hA123, 0);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: cwr(16'($urandom_range(0, 3) * 16'h2000 + $urandom_range(0, 16'h1FFF)), 8'($urandom));
        1: crd(16'($urandom_range(0, 16'h7FFF)), int'($urandom_range(0, 3)));
        2: crd(16'(16'hA000 + $urandom_range(0, 16'h1FFF)), int'($urandom_range(0, 3)));
        default: cwr(16'(16'hA000 + $urandom_range(0, 16'h1FFF)), 8'($urandom));
      endcase
    end
    cwr(16'h0000, 8'h0A);
    cwr(16'h4000, 8'h02);
    cwr(16'h6000, 8'h01);
    cwr(16'hA001, 8'h5A);
    crd(16'hA001, 1);
    if (RAM_BUILD) begin
      cart_addr = 16'hA001; cart_di = 8'h11; cart_wr = 1'b1;
      cyc(1);
      cart_wr = 1'b0;
      chk("b2b_first", {10'b0, mem_addr}, 32'h204001);
      cyc(1);
      cart_addr = 16'hA002; cart_di = 8'h77; cart_wr = 1'b1;
      cyc(1);
      cart_wr = 1'b0;
      cyc(3);
      chk("b2b_still_first", {24'b0, mem_wdata}, 32'h11);
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      chk("b2b_gap", {31'b0, mem_req}, 32'd0);
      cyc(1);
      chk("b2b_second_req", {31'b0, mem_req}, 32'd1);
      chk("b2b_second_addr", {10'b0, mem_addr}, 32'h204002);
      chk("b2b_second_data", {24'b0, mem_wdata}, 32'h77);
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      cyc(1);
      chk("b2b_idle", {31'b0, mem_req}, 32'd0);
    end
    crd(16'h0200, 0);
    cart_addr = 16'h0100; cart_rd = 1'b1;
    cyc(1);
    chk("mid_req", {31'b0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_req", {31'b0, mem_req}, 32'd0);
    chk("async_busy", {31'b0, cart_busy}, 32'd0);
    chk("async_do", {24'b0, cart_do}, 32'hFF);
    chk("async_we", {31'b0, mem_we}, 32'd0);
    cart_rd = 1'b0;
    model_reset();
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    mem_ack = 1'b1; mem_rdata = 8'h12;
    cyc(1);
    mem_ack = 1'b0;
    chk("late_ack_do", {24'b0, cart_do}, 32'hFF);
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_busy", {31'b0, cart_busy}, 32'd0);
    crd(16'h4000, 0);
    chk("post_rst_bank", {10'b0, obs_addr}, 32'h004000);
    crd(16'hA000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
